// File: rtl/hamming_byte_enc_seq_if.sv
// Byte-in / codeword-out handshake bundle for the Hamming byte sequencer.
// Latency: none, wiring only.
// Backpressure: valid/ready on both channels; the slave owns in_ready and the out_* channel.
interface hamming_byte_enc_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_code;
    logic       out_last;

    // Encoder side: consumes bytes, produces codewords
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_code, out_last
    );

    // Source/sink side: produces bytes, consumes codewords
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_code, out_last
    );
endinterface

// File: rtl/hamming_byte_enc_seq.sv
// Splits each byte into two nibbles and emits each as a Hamming(7,4)+overall-parity codeword.
// Latency: first codeword 1 cycle after byte accept, second 1 cycle after first is taken.
// Backpressure: out_code/out_last held stable while out_ready=0; in_ready opens only in IDLE or on the final handshake.
// Optional: define HAMMING_SEQ_CNT_EN to add cnt_bytes, a wrapping count of fully delivered bytes.
module hamming_byte_enc_seq #(
    parameter bit MSN_FIRST = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    hamming_byte_enc_seq_if.slave  bus,
    output logic                   busy
`ifdef HAMMING_SEQ_CNT_EN
    ,
    output logic [15:0]            cnt_bytes
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND0 = 2'd1,
        SEND1 = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_data;
    logic [7:0] r_code;
    logic       r_last;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_load_second;

    // {overall_parity, d3, d2, d1, p4, d0, p2, p1}
    function automatic logic [7:0] enc(input logic [3:0] d);
        logic [6:0] h;
        h = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
        return {^h, h};
    endfunction

    function automatic logic [3:0] first_nib(input logic [7:0] b);
        return MSN_FIRST ? b[7:4] : b[3:0];
    endfunction

    function automatic logic [3:0] second_nib(input logic [7:0] b);
        return MSN_FIRST ? b[3:0] : b[7:4];
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake decode; SEND1 hands straight over to a new byte with no bubble
    always_comb begin
        w_state_nxt   = r_state;
        w_in_ready    = 1'b0;
        w_load_second = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = SEND0;
                end
            end
            SEND0: begin
                if (bus.out_ready) begin
                    w_load_second = 1'b1;
                    w_state_nxt   = SEND1;
                end
            end
            SEND1: begin
                if (bus.out_ready) begin
                    w_in_ready  = 1'b1;
                    w_state_nxt = bus.in_valid ? SEND0 : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_accept = bus.in_valid & w_in_ready;
    end

    // Byte capture and codeword register; untouched unless a handshake advances the sequence
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= 8'h00;
            r_code <= 8'h00;
            r_last <= 1'b0;
        end else if (w_accept) begin
            r_data <= bus.in_data;
            r_code <= enc(first_nib(bus.in_data));
            r_last <= 1'b0;
        end else if (w_load_second) begin
            r_code <= enc(second_nib(r_data));
            r_last <= 1'b1;
        end
    end

`ifdef HAMMING_SEQ_CNT_EN
    logic [15:0] r_cnt;

    // Count bytes whose final codeword was taken; wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 16'h0000;
        end else if ((r_state != IDLE) && bus.out_ready && r_last) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign cnt_bytes = r_cnt;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state != IDLE);
    assign bus.out_code  = r_code;
    assign bus.out_last  = r_last;
    assign busy          = (r_state != IDLE);

endmodule
